byte_stream_word_packer: RTL

//  Drains the second (output-side) FIFO of the double-buffer path: issues FIFO

---
 rtl/byte_stream_word_packer_if.sv | 13 +
 rtl/byte_stream_word_packer.sv | 91 +++++++++
 2 files changed

// File: rtl/byte_stream_word_packer_if.sv
// Output stream of the word packer: packed word, valid/ready handshake and
// end-of-line flag.
interface byte_stream_word_packer_if #(
    parameter int OUT_W = 32
);
    logic [OUT_W-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic             out_last;

    modport master (output out_data, output out_valid, output out_last, input out_ready);
    modport slave  (input out_data, input out_valid, input out_last, output out_ready);
endinterface

// File: rtl/byte_stream_word_packer.sv
// Drains the output-side FIFO, packs PACK narrow entries little-endian into one
// wide word and presents it on a valid/ready stream with an end-of-line flag.
module byte_stream_word_packer #(
    parameter int IN_W       = 8,
    parameter int PACK       = 4,
    parameter int LINE_WORDS = 640
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         enable,
    input  logic                         fifo_empty,
    output logic                         fifo_rd,
    input  logic                         fifo_valid,
    input  logic [IN_W-1:0]              fifo_dout,
    byte_stream_word_packer_if.master    out_if,
    output logic                         busy
);
    localparam int OUT_W = IN_W * PACK;
    localparam int CNT_W = $clog2(PACK + 1);
    localparam int WC_W  = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;

    logic [OUT_W-1:0] asm_q;
    logic [CNT_W-1:0] asm_cnt;
    logic             inflight;
    logic [OUT_W-1:0] out_data_q;
    logic             out_valid_q;
    logic             out_last_q;
    logic [WC_W-1:0]  word_cnt;

    logic             asm_full;
    logic             accept;
    logic             transfer;
    logic             next_is_last;
    logic [CNT_W:0]   pending;

    assign asm_full = (asm_cnt == CNT_W'(PACK));
    assign accept   = out_valid_q & out_if.out_ready;
    assign transfer = asm_full & (~out_valid_q | out_if.out_ready);
    assign pending  = {1'b0, asm_cnt} + {{CNT_W{1'b0}}, inflight};
    assign fifo_rd  = reset & enable & ~fifo_empty & (pending < (CNT_W + 1)'(PACK));

    // A word still sitting in the output register when a new one is loaded is
    // being accepted this same cycle, so the new word's line index is one
    // further on than word_cnt.
    always_comb begin
        next_is_last = 1'b0;
        if (LINE_WORDS == 1) begin
            next_is_last = 1'b1;
        end else if (out_valid_q) begin
            next_is_last = (int'(word_cnt) == LINE_WORDS - 2);
        end else begin
            next_is_last = (int'(word_cnt) == LINE_WORDS - 1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            asm_q       <= '0;
            asm_cnt     <= '0;
            inflight    <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            word_cnt    <= '0;
        end else begin
            inflight <= fifo_rd;
            if (transfer) begin
                out_data_q  <= asm_q;
                out_valid_q <= 1'b1;
                out_last_q  <= next_is_last;
                asm_cnt     <= '0;
            end else begin
                if (accept) begin
                    out_valid_q <= 1'b0;
                end
                if (fifo_valid && !asm_full) begin
                    asm_q[int'(asm_cnt) * IN_W +: IN_W] <= fifo_dout;
                    asm_cnt <= asm_cnt + CNT_W'(1);
                end
            end
            if (accept) begin
                word_cnt <= (int'(word_cnt) == LINE_WORDS - 1) ? '0 : word_cnt + WC_W'(1);
            end
        end
    end

    assign out_if.out_data  = out_data_q;
    assign out_if.out_valid = out_valid_q;
    assign out_if.out_last  = out_last_q;
    assign busy             = (asm_cnt != '0) | inflight | out_valid_q;
endmodule
